// File: rtl/rv_plic_target_ctrl.sv
// PLIC target controller: picks the best eligible source for one hart and
// turns claim reads and complete writes into one-hot gateway pulses.
module rv_plic_target_ctrl #(
  parameter  int N_SOURCE = 32,
  parameter  int PRIO_W   = 3,
  localparam int ID_W     = $clog2(N_SOURCE + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SOURCE-1:0]        ip,
  input  logic [N_SOURCE-1:0]        ie,
  input  logic [N_SOURCE*PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]          threshold,
  input  logic                       claim_req_i,
  output logic                       claim_busy_o,
  output logic                       claim_valid_o,
  output logic [ID_W-1:0]            claim_id_o,
  input  logic                       complete_req_i,
  input  logic [ID_W-1:0]            complete_id_i,
  output logic                       irq_o,
  output logic [ID_W-1:0]            irq_id_o,
  output logic [N_SOURCE-1:0]        claim,
  output logic [N_SOURCE-1:0]        complete,
  output logic [N_SOURCE-1:0]        claimed_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     cid_q, cid_d;
  logic [ID_W-1:0]     best_id_q, best_id_d;
  logic [N_SOURCE-1:0] claimed_q, claimed_d;
  logic [N_SOURCE-1:0] complete_q, complete_d;
  logic [N_SOURCE-1:0] clm_hit, cpl_hit;
  logic [PRIO_W-1:0]   best_prio;

  // Strict '>' against the running best keeps the lowest index on ties.
  always_comb begin
    best_id_d = '0;
    best_prio = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (ip[i] && ie[i] &&
          (prio[i*PRIO_W +: PRIO_W] > threshold) &&
          (prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio[i*PRIO_W +: PRIO_W];
        best_id_d = ID_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cid_d         = cid_q;
    claim_busy_o  = 1'b0;
    claim_valid_o = 1'b0;
    claim_id_o    = '0;
    clm_hit       = '0;
    case (state_q)
      IDLE: begin
        if (claim_req_i) begin
          cid_d   = best_id_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        claim_busy_o  = 1'b1;
        claim_valid_o = 1'b1;
        claim_id_o    = cid_q;
        for (int i = 0; i < N_SOURCE; i++) begin
          if (cid_q == ID_W'(i + 1)) clm_hit[i] = 1'b1;
        end
        state_d = SETTLE;
      end
      SETTLE: begin
        claim_busy_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only IDs that are currently claimed can match, so 0 and out-of-range IDs drop.
  always_comb begin
    cpl_hit = '0;
    if (complete_req_i) begin
      for (int i = 0; i < N_SOURCE; i++) begin
        if ((complete_id_i == ID_W'(i + 1)) && claimed_q[i]) cpl_hit[i] = 1'b1;
      end
    end
    complete_d = cpl_hit;
    claimed_d  = (claimed_q & ~cpl_hit) | clm_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cid_q      <= '0;
      best_id_q  <= '0;
      claimed_q  <= '0;
      complete_q <= '0;
    end else begin
      state_q    <= state_d;
      cid_q      <= cid_d;
      best_id_q  <= best_id_d;
      claimed_q  <= claimed_d;
      complete_q <= complete_d;
    end
  end

  // irq is masked while a claim is in flight so the hart never sees a stale ID.
  assign irq_id_o  = best_id_q;
  assign irq_o     = (best_id_q != '0) && (state_q == IDLE);
  assign claim     = clm_hit;
  assign complete  = complete_q;
  assign claimed_o = claimed_q;

endmodule

// File: tb/tb_rv_plic_target_ctrl.sv
// Directed bench for rv_plic_target_ctrl with hand-computed expectations.
module tb_rv_plic_target_ctrl;

  localparam int N_SOURCE = 32;
  localparam int PRIO_W   = 3;
  localparam int ID_W     = 6;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [N_SOURCE-1:0]        ip;
  logic [N_SOURCE-1:0]        ie;
  logic [N_SOURCE*PRIO_W-1:0] prio;
  logic [PRIO_W-1:0]          threshold;
  logic                       claim_req_i;
  logic                       claim_busy_o;
  logic                       claim_valid_o;
  logic [ID_W-1:0]            claim_id_o;
  logic                       complete_req_i;
  logic [ID_W-1:0]            complete_id_i;
  logic                       irq_o;
  logic [ID_W-1:0]            irq_id_o;
  logic [N_SOURCE-1:0]        claim;
  logic [N_SOURCE-1:0]        complete;
  logic [N_SOURCE-1:0]        claimed_o;

  int n_checks = 0;
  int n_fail   = 0;

  rv_plic_target_ctrl #(.N_SOURCE(N_SOURCE), .PRIO_W(PRIO_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ip             (ip),
    .ie             (ie),
    .prio           (prio),
    .threshold      (threshold),
    .claim_req_i    (claim_req_i),
    .claim_busy_o   (claim_busy_o),
    .claim_valid_o  (claim_valid_o),
    .claim_id_o     (claim_id_o),
    .complete_req_i (complete_req_i),
    .complete_id_i  (complete_id_i),
    .irq_o          (irq_o),
    .irq_id_o       (irq_id_o),
    .claim          (claim),
    .complete       (complete),
    .claimed_o      (claimed_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // All driving and sampling happens 1 ns after a rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_prio(input int idx, input logic [PRIO_W-1:0] val);
    prio[idx*PRIO_W +: PRIO_W] = val;
  endtask

  logic [N_SOURCE-1:0] saved;

  initial begin
    rst_i          = 1'b1;
    ip             = '0;
    ie             = '0;
    prio           = '0;
    threshold      = '0;
    claim_req_i    = 1'b0;
    complete_req_i = 1'b0;
    complete_id_i  = '0;
    step();
    step();
    check("rst_irq",     64'(irq_o), 64'd0);
    check("rst_valid",   64'(claim_valid_o), 64'd0);
    check("rst_claimed", 64'(claimed_o), 64'd0);
    check("rst_busy",    64'(claim_busy_o), 64'd0);
    rst_i = 1'b0;
    step();
    check("post_rst_irq_id", 64'(irq_id_o), 64'd0);

    // Basic claim of source 5 (ID 6)
    set_prio(5, 3'd3);
    ie[5] = 1'b1;
    ip[5] = 1'b1;
    check("irq_not_yet", 64'(irq_o), 64'd0);
    step();
    check("basic_irq",    64'(irq_o), 64'd1);
    check("basic_irq_id", 64'(irq_id_o), 64'd6);
    claim_req_i = 1'b1;
    step();
    claim_req_i = 1'b0;
    check("basic_claim",    64'(claim), 64'h20);
    check("basic_valid",    64'(claim_valid_o), 64'd1);
    check("basic_claim_id", 64'(claim_id_o), 64'd6);
    check("basic_busy",     64'(claim_busy_o), 64'd1);
    check("issue_irq_mask", 64'(irq_o), 64'd0);
    ip[5] = 1'b0;
    step();
    check("basic_claimed",   64'(claimed_o), 64'h20);
    check("settle_irq_mask", 64'(irq_o), 64'd0);
    check("settle_valid",    64'(claim_valid_o), 64'd0);
    check("settle_claim",    64'(claim), 64'd0);
    step();
    check("idle_busy", 64'(claim_busy_o), 64'd0);
    check("idle_irq",  64'(irq_o), 64'd0);

    // Complete filtering
    complete_req_i = 1'b1;
    complete_id_i  = 6'd6;
    step();
    complete_req_i = 1'b0;
    check("cpl_pulse",   64'(complete), 64'h20);
    check("cpl_claimed", 64'(claimed_o), 64'd0);
    step();
    check("cpl_one_cycle", 64'(complete), 64'd0);
    complete_req_i = 1'b1;
    step();
    check("cpl_dup", 64'(complete), 64'd0);
    complete_id_i = 6'd0;
    step();
    check("cpl_id0", 64'(complete), 64'd0);
    complete_id_i = 6'd33;
    step();
    check("cpl_id33", 64'(complete), 64'd0);
    complete_req_i = 1'b0;

    // Tie-break and priority
    ie = '1;
    set_prio(2, 3'd4);
    set_prio(9, 3'd4);
    ip[2] = 1'b1;
    ip[9] = 1'b1;
    step();
    check("tie_id", 64'(irq_id_o), 64'd3);
    set_prio(9, 3'd5);
    check("prio_latency", 64'(irq_id_o), 64'd3);
    step();
    check("prio_id", 64'(irq_id_o), 64'd10);

    // Threshold
    ip = '0;
    ip[4] = 1'b1;
    set_prio(4, 3'd2);
    threshold = 3'd2;
    step();
    check("thr_eq_irq", 64'(irq_o), 64'd0);
    threshold = 3'd1;
    step();
    check("thr_lo_irq", 64'(irq_o), 64'd1);
    check("thr_lo_id",  64'(irq_id_o), 64'd5);
    ie[4] = 1'b0;
    step();
    check("ie_off_irq", 64'(irq_o), 64'd0);

    // Empty claim
    ip = '0;
    step();
    saved = claimed_o;
    claim_req_i = 1'b1;
    step();
    claim_req_i = 1'b0;
    check("empty_valid", 64'(claim_valid_o), 64'd1);
    check("empty_id",    64'(claim_id_o), 64'd0);
    check("empty_claim", 64'(claim), 64'd0);
    step();
    check("empty_claimed", 64'(claimed_o), 64'(saved));
    check("empty_busy",    64'(claim_busy_o), 64'd1);
    step();

    // Busy: requests held through ISSUE and SETTLE are ignored
    ie = '0;
    ie[5] = 1'b1;
    threshold = 3'd0;
    ip[5] = 1'b1;
    step();
    claim_req_i = 1'b1;
    step();
    check("busy_valid_issue", 64'(claim_valid_o), 64'd1);
    step();
    check("busy_valid_settle", 64'(claim_valid_o), 64'd0);
    step();
    claim_req_i = 1'b0;
    check("busy_valid_idle", 64'(claim_valid_o), 64'd0);
    check("busy_idle",       64'(claim_busy_o), 64'd0);
    step();
    check("busy_no_reissue", 64'(claim_valid_o), 64'd0);
    check("busy_claimed",    64'(claimed_o), 64'h20);

    // Simultaneous complete of ID 6 and claim of ID 6 again
    claim_req_i    = 1'b1;
    step();
    claim_req_i    = 1'b0;
    check("sim_claim", 64'(claim), 64'h20);
    complete_req_i = 1'b1;
    complete_id_i  = 6'd6;
    step();
    complete_req_i = 1'b0;
    check("sim_complete", 64'(complete), 64'h20);
    check("sim_claimed",  64'(claimed_o), 64'h20);
    step();

    // Asynchronous reset in the middle of ISSUE
    claim_req_i = 1'b1;
    step();
    check("rst_pre_valid", 64'(claim_valid_o), 64'd1);
    #1;
    rst_i = 1'b1;
    #1;
    check("arst_claim",   64'(claim), 64'd0);
    check("arst_valid",   64'(claim_valid_o), 64'd0);
    check("arst_irq",     64'(irq_o), 64'd0);
    check("arst_claimed", 64'(claimed_o), 64'd0);
    claim_req_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    check("rel_busy",   64'(claim_busy_o), 64'd0);
    check("rel_valid",  64'(claim_valid_o), 64'd0);
    check("rel_irq",    64'(irq_o), 64'd1);
    check("rel_irq_id", 64'(irq_id_o), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
